// File: rtl/sr_stim_sequencer_pkg.sv
// Shared definitions for the set-reset stimulus sequencer: timing-mode codes
// and FSM state encodings used by the top level and the testbench.
package sr_stim_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LEAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_FIN  = 2'd3
   } state_e;

   localparam logic [1:0] MODE_AT_RISE   = 2'd0;
   localparam logic [1:0] MODE_PRE_FALL  = 2'd1;
   localparam logic [1:0] MODE_POST_FALL = 2'd2;
   localparam logic [1:0] MODE_ILLEGAL   = 2'd3;

endpackage

// File: rtl/sr_stim_sequencer_table.sv
// Vector table: NVEC rows of {s,r}. One synchronous write port and one
// combinational read port. Storage has no reset, so a sequencer reset
// leaves the loaded vectors intact.
// Ports:
//   clk      clock
//   we_i     write strobe (already qualified by the caller)
//   waddr_i  write row; rows >= NVEC are dropped
//   wdata_i  {s,r} row data
//   raddr_i  read row; rows >= NVEC read as 0
//   rdata_o  {s,r} at raddr_i
module sr_vec_table #(
   parameter int NVEC   = 26,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [1:0]        wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [1:0]        rdata_o
);

   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NVEC - 1);

   logic [1:0] mem_q [NVEC];

   always_ff @(posedge clk) begin
      if (we_i && (waddr_i <= LAST_ROW)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = (raddr_i <= LAST_ROW) ? mem_q[raddr_i] : 2'b00;

endmodule

// File: rtl/sr_stim_sequencer.sv
// Stimulus sequencer for set-reset latch/flip-flop DUTs. Replays the vector
// table as {s,r} against a gate g in one of three timing modes, samples the
// DUT q/qb at the end of each slot and flags non-complementary outputs.
// Ports:
//   clk, reset_L              clock, synchronous active-low reset
//   start, mode               run request (IDLE only) and timing mode
//   vec_we/vec_waddr/vec_wdata table write port, blocked while busy
//   q_in, qb_in               DUT outputs
//   s, r, g                   registered DUT stimulus
//   busy, done, mode_err      run status
//   vec_idx                   row currently applied
//   smp_valid, smp_q, smp_qb  per-slot sample
//   err_eq, err_cnt           sticky equal-output flag and count
//
// state   | meaning
// IDLE    | waiting for start; table writable
// LEAD    | PERIOD cycles of s=r=g=0 before the first vector
// RUN     | replaying slots, tick down-counter per slot
// FIN     | one-cycle done pulse, then back to IDLE
module sr_stim_sequencer
   import sr_stim_sequencer_pkg::*;
#(
   parameter int NVEC   = 26,
   parameter int ADDR_W = 5,
   parameter int PERIOD = 1000,
   parameter int T_HIGH = 21,
   parameter int T_PRE  = 19,
   parameter int T_POST = 1,
   parameter int CNT_W  = 10
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic              vec_we,
   input  logic [ADDR_W-1:0] vec_waddr,
   input  logic [1:0]        vec_wdata,
   input  logic              q_in,
   input  logic              qb_in,
   output logic              s,
   output logic              r,
   output logic              g,
   output logic              busy,
   output logic              done,
   output logic              mode_err,
   output logic [ADDR_W-1:0] vec_idx,
   output logic              smp_valid,
   output logic              smp_q,
   output logic              smp_qb,
   output logic              err_eq,
   output logic [ADDR_W-1:0] err_cnt
);

   // The slot counter counts down: remaining = PERIOD-1-tick. Tick-based
   // event points are converted to remaining-count compares here.
   localparam logic [CNT_W-1:0]  CNT_TOP    = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0]  CNT_HALF   = CNT_W'(PERIOD / 2);
   localparam logic [CNT_W-1:0]  CNT_GFALL0 = CNT_W'(PERIOD - 1 - T_HIGH);
   localparam logic [CNT_W-1:0]  CNT_APPLY1 = CNT_W'(PERIOD / 2 - 1 + T_PRE);
   localparam logic [CNT_W-1:0]  CNT_APPLY2 = CNT_W'(PERIOD - 1 - T_POST);
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NVEC - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [1:0]        mode_q, mode_d;
   logic              s_q, s_d, r_q, r_d, g_q, g_d;
   logic              busy_q, busy_d, done_q, done_d, mode_err_q, mode_err_d;
   logic              smp_valid_q, smp_valid_d, smp_q_q, smp_q_d, smp_qb_q, smp_qb_d;
   logic              err_eq_q, err_eq_d;
   logic [ADDR_W-1:0] err_cnt_q, err_cnt_d;
   logic [1:0]        row;
   logic              slot_end;

   sr_vec_table #(
      .NVEC   (NVEC),
      .ADDR_W (ADDR_W)
   ) u_table (
      .clk     (clk),
      .we_i    (vec_we && !busy_q),
      .waddr_i (vec_waddr),
      .wdata_i (vec_wdata),
      .raddr_i (idx_q),
      .rdata_o (row)
   );

   assign slot_end = (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         mode_q      <= MODE_AT_RISE;
         s_q         <= 1'b0;
         r_q         <= 1'b0;
         g_q         <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mode_err_q  <= 1'b0;
         smp_valid_q <= 1'b0;
         smp_q_q     <= 1'b0;
         smp_qb_q    <= 1'b0;
         err_eq_q    <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         mode_q      <= mode_d;
         s_q         <= s_d;
         r_q         <= r_d;
         g_q         <= g_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         mode_err_q  <= mode_err_d;
         smp_valid_q <= smp_valid_d;
         smp_q_q     <= smp_q_d;
         smp_qb_q    <= smp_qb_d;
         err_eq_q    <= err_eq_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start && (mode != MODE_ILLEGAL)) state_d = ST_LEAD;
         ST_LEAD: if (slot_end) state_d = ST_RUN;
         ST_RUN:  if (slot_end && (idx_q == LAST_IDX)) state_d = ST_FIN;
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      mode_d      = mode_q;
      s_d         = s_q;
      r_d         = r_q;
      g_d         = g_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      mode_err_d  = 1'b0;
      smp_valid_d = 1'b0;
      smp_q_d     = smp_q_q;
      smp_qb_d    = smp_qb_q;
      err_eq_d    = err_eq_q;
      err_cnt_d   = err_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (mode == MODE_ILLEGAL) begin
                  mode_err_d = 1'b1;
               end else begin
                  mode_d    = mode;
                  err_eq_d  = 1'b0;
                  err_cnt_d = '0;
                  busy_d    = 1'b1;
                  cnt_d     = CNT_TOP;
                  idx_d     = '0;
                  s_d       = 1'b0;
                  r_d       = 1'b0;
                  g_d       = 1'b0;
               end
            end
         end

         ST_LEAD: begin
            cnt_d = slot_end ? CNT_TOP : cnt_q - CNT_W'(1);
         end

         ST_RUN: begin
            cnt_d = slot_end ? CNT_TOP : cnt_q - CNT_W'(1);

            case (mode_q)
               MODE_AT_RISE: begin
                  if (cnt_q == CNT_TOP) begin
                     {s_d, r_d} = row;
                     g_d        = 1'b1;
                  end
                  if (cnt_q == CNT_GFALL0) g_d = 1'b0;
               end
               MODE_PRE_FALL: begin
                  g_d = (cnt_q >= CNT_HALF);
                  if (cnt_q == CNT_APPLY1) {s_d, r_d} = row;
               end
               MODE_POST_FALL: begin
                  g_d = (cnt_q < CNT_HALF);
                  if (cnt_q == CNT_APPLY2) {s_d, r_d} = row;
               end
               default: ;
            endcase

            if (slot_end) begin
               smp_valid_d = 1'b1;
               smp_q_d     = q_in;
               smp_qb_d    = qb_in;
               if (q_in == qb_in) begin
                  err_eq_d = 1'b1;
                  if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ADDR_W'(1);
               end
               if (idx_q == LAST_IDX) begin
                  busy_d = 1'b0;
                  done_d = 1'b1;
               end else begin
                  idx_d = idx_q + ADDR_W'(1);
               end
            end
         end

         default: ;
      endcase
   end

   assign s         = s_q;
   assign r         = r_q;
   assign g         = g_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign mode_err  = mode_err_q;
   assign vec_idx   = idx_q;
   assign smp_valid = smp_valid_q;
   assign smp_q     = smp_q_q;
   assign smp_qb    = smp_qb_q;
   assign err_eq    = err_eq_q;
   assign err_cnt   = err_cnt_q;

endmodule
